// File: rtl/av_note_scheduler.sv
// -----------------------------------------------------------------------------
// av_note_scheduler
//
// Chart-reader front end for the AV string renderers. It walks a song-chart
// ROM in address order. Each note event (fret, fret_en, fret_time) is emitted
// a fixed LOOKAHEAD ahead of its hit time, so the notes scroll into view
// before song_time reaches them. All logic runs on the clk65 domain.
//
// Ports
//   i_clk65          pixel/system clock, rising edge
//   i_reset          synchronous, active-high reset (takes priority over start)
//   i_start          1-cycle pulse: rewind to entry 0 and begin a song
//   i_pause          hold: no emission, pointer frozen at the pending entry
//   i_song_time      current song position (same units as chart hit times)
//   o_rom_addr       chart ROM read address (always the entry pointer)
//   i_rom_data       {hit_time[51:36], fret[35:6], en[5:0]}, valid 1 cycle
//                    after o_rom_addr
//   o_fret           5 bits per string, string6 in [29:25] .. string1 in [4:0]
//   o_fret_time      hit time of the emitted event
//   o_fret_en        per-string enable, nonzero only in the emit pulse
//   o_busy           high from start until DONE
//   o_done           high in DONE until the next start or reset
//   o_notes_emitted  emit pulses since the last start
//   o_dbg_state      current FSM state, for debug and checkers
//
// Interface timing
//   ROM side: o_rom_addr is presented in FETCH. i_rom_data is sampled at the
//   end of WAIT, one cycle later.
//   Output side: there is no back-pressure. An event is "valid" for exactly
//   one cycle, the EMIT cycle. In that cycle o_notes_emitted has already
//   advanced. o_fret_en carries the entry's enables, and may be all-zero for
//   a consumed empty entry.
// -----------------------------------------------------------------------------
module av_note_scheduler #(
  parameter int          ADDR_W    = 12,
  parameter logic [15:0] LOOKAHEAD = 16'd2000
) (
  input  logic              i_clk65,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic [15:0]       i_song_time,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [51:0]       i_rom_data,
  output logic [29:0]       o_fret,
  output logic [15:0]       o_fret_time,
  output logic [5:0]        o_fret_en,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_notes_emitted,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [51:0]       r_entry;
  logic [29:0]       r_fret;
  logic [15:0]       r_fret_time;
  logic [5:0]        r_fret_en;
  logic              r_busy;
  logic              r_done;
  logic [15:0]       r_notes;

  logic [15:0]       w_entry_time;
  logic [29:0]       w_entry_fret;
  logic [5:0]        w_entry_en;
  logic              w_is_marker;
  logic              w_due;
  logic              w_ptr_last;
  logic              w_emit_go;

  assign w_entry_time = r_entry[51:36];
  assign w_entry_fret = r_entry[35:6];
  assign w_entry_en   = r_entry[5:0];

  // End-of-chart marker: no strings enabled and the maximum hit time.
  assign w_is_marker  = (w_entry_en == 6'd0) && (w_entry_time == 16'hFFFF);

  // The sum is done in 17 bits. Without that, a song_time near the top of
  // the range would wrap and late-chart notes would never come due.
  assign w_due        = ({1'b0, w_entry_time}) <=
                        ({1'b0, i_song_time} + {1'b0, LOOKAHEAD});

  // The last ROM slot ends the song even without a marker. The pointer
  // never wraps back to 0.
  assign w_ptr_last   = (r_ptr == {ADDR_W{1'b1}});

  // Next-state logic. A start pulse overrides every state, so it also
  // cancels a pending CHECK->EMIT decision in the same cycle.
  always_comb begin
    w_next = r_state;
    if (i_start) begin
      w_next = S_FETCH;
    end else begin
      case (r_state)
        S_IDLE:  w_next = S_IDLE;
        S_FETCH: w_next = S_WAIT;
        S_WAIT:  w_next = S_CHECK;
        S_CHECK: begin
          if (w_is_marker)          w_next = S_DONE;
          else if (!i_pause && w_due) w_next = S_EMIT;
          else                      w_next = S_CHECK;
        end
        S_EMIT:  w_next = w_ptr_last ? S_DONE : S_FETCH;
        S_DONE:  w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Outputs are registered. They are loaded on the edge that enters EMIT,
  // so the pulse is aligned with the EMIT state.
  assign w_emit_go = (r_state == S_CHECK) && (w_next == S_EMIT);

  always_ff @(posedge i_clk65) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_entry     <= '0;
      r_fret      <= '0;
      r_fret_time <= '0;
      r_fret_en   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_notes     <= '0;
    end else begin
      r_state <= w_next;

      if (i_start) begin
        r_ptr <= '0;
      end else if ((r_state == S_EMIT) && !w_ptr_last) begin
        r_ptr <= r_ptr + ADDR_W'(1);
      end

      if (r_state == S_WAIT) begin
        r_entry <= i_rom_data;
      end

      if (w_emit_go) begin
        r_fret      <= w_entry_fret;
        r_fret_time <= w_entry_time;
        r_fret_en   <= w_entry_en;
      end else begin
        r_fret_en   <= 6'd0;
      end

      if (i_start) begin
        r_notes <= '0;
      end else if (w_emit_go) begin
        r_notes <= r_notes + 16'd1;
      end

      r_busy <= (w_next == S_FETCH) || (w_next == S_WAIT) ||
                (w_next == S_CHECK) || (w_next == S_EMIT);
      r_done <= (w_next == S_DONE);
    end
  end

  assign o_rom_addr      = r_ptr;
  assign o_fret          = r_fret;
  assign o_fret_time     = r_fret_time;
  assign o_fret_en       = r_fret_en;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_notes_emitted = r_notes;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_av_note_scheduler.sv
// -----------------------------------------------------------------------------
// tb_av_note_scheduler
//
// Drives av_note_scheduler (ADDR_W=3, 8-entry chart ROM) through directed
// scenarios and randomized charts. Each expected emit event carries its
// exact emit cycle, count, time, fret and enables. The event is queued
// when the stimulus is issued. A negedge monitor pops the queue whenever
// the DUT presents an emit pulse.
// -----------------------------------------------------------------------------
module tb_av_note_scheduler;

  localparam int          AW = 3;
  localparam int          N  = 1 << AW;
  localparam int          W  = 100;
  localparam logic [16:0] LA = 17'd2000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          pause;
  logic [15:0]   song;
  logic [AW-1:0] rom_addr;
  logic [51:0]   rom_data;
  logic [29:0]   fret;
  logic [15:0]   fret_time;
  logic [5:0]    fret_en;
  logic          busy;
  logic          done;
  logic [15:0]   notes;
  logic [2:0]    dbg_state;

  logic [51:0]   rom [N];
  logic [W-1:0]  exp_q[$];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [15:0]   prev_notes = 16'd0;

  logic [15:0]   hit [N];
  logic [29:0]   frv [N];
  logic [5:0]    env [N];

  av_note_scheduler #(.ADDR_W(AW), .LOOKAHEAD(16'd2000)) dut (
    .i_clk65        (clk),
    .i_reset        (rst),
    .i_start        (start),
    .i_pause        (pause),
    .i_song_time    (song),
    .o_rom_addr     (rom_addr),
    .i_rom_data     (rom_data),
    .o_fret         (fret),
    .o_fret_time    (fret_time),
    .o_fret_en      (fret_en),
    .o_busy         (busy),
    .o_done         (done),
    .o_notes_emitted(notes),
    .o_dbg_state    (dbg_state)
  );

  // ---------------- clock / reset / ROM ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] pack(input int c, input logic [15:0] n,
                                        input logic [15:0] t, input logic [29:0] f,
                                        input logic [5:0] e);
    return {c[31:0], n, t, f, e};
  endfunction

  function automatic logic [51:0] ent(input logic [15:0] t, input logic [29:0] f,
                                      input logic [5:0] e);
    return {t, f, e};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_pulse(output int t0);
    @(posedge clk);
    #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < N; i++) rom[i] = ent(16'hFFFF, 30'd0, 6'd0);
  endtask

  task automatic end_check(input string name, input int exp_notes);
    chk({name, "_done"}, 64'(done), 64'd1);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_notes"}, 64'(notes), 64'(exp_notes));
    chk({name, "_fret_en_idle"}, 64'(fret_en), 64'd0);
    chk({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic         emit_seen;
    logic [W-1:0] item;
    if (!rst) begin
      emit_seen = (fret_en != 6'd0) || ((notes != prev_notes) && (notes != 16'd0));
      if (emit_seen) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_emit: got notes=%0d fret_en=%0h expected no emit (cycle %0d)",
                   notes, fret_en, cyc);
        end else begin
          item = exp_q.pop_front();
          chk("emit_cycle", 64'(cyc), 64'(item[99:68]));
          chk("emit_notes", 64'(notes), 64'(item[67:52]));
          chk("emit_fret_time", 64'(fret_time), 64'(item[51:36]));
          chk("emit_fret", 64'(fret), 64'(item[35:6]));
          chk("emit_fret_en", 64'(fret_en), 64'(item[5:0]));
        end
      end
    end
    prev_notes <= notes;
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int t1;
    int e;
    int c;
    int tr;
    int n;
    logic [15:0] st;
    logic [15:0] tt;

    rst = 1'b1; start = 1'b0; pause = 1'b0; song = 16'd0;
    clear_rom();
    tick(2);
    rst = 1'b0;

    // Reset then idle: everything stays zero with no start.
    for (int k = 0; k < 3; k++) begin
      tick(5);
      chk("idle_rom_addr", 64'(rom_addr), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_outputs", 64'({fret, fret_time, fret_en}), 64'd0);
      chk("idle_notes", 64'(notes), 64'd0);
    end
    chk("idle_state", 64'(dbg_state), 64'd0);

    // Basic emit: fourth cycle after start.
    rom[0] = ent(16'd100, 30'h1, 6'h01);
    start_pulse(t0);
    exp_q.push_back(pack(t0 + 4, 16'd1, 16'd100, 30'h1, 6'h01));
    chk("basic_busy_after_start", 64'(busy), 64'd1);
    tick(10);
    end_check("basic", 1);

    // Lookahead gate: song_time ramps, emit the cycle after it hits 3000.
    clear_rom();
    rom[0] = ent(16'd5000, 30'h2A5, 6'h3F);
    song = 16'd0;
    start_pulse(t0);
    exp_q.push_back(pack(t0 + 31, 16'd1, 16'd5000, 30'h2A5, 6'h3F));
    for (int k = 2; k <= 40; k++) begin
      tick(1);
      song = 16'(k * 100);
    end
    tick(5);
    end_check("lookahead", 1);

    // Pause: condition met, held for 50 cycles, emit right after release.
    clear_rom();
    rom[0] = ent(16'd200, 30'h3FFFFFFF, 6'h2A);
    song = 16'd0;
    pause = 1'b1;
    start_pulse(t0);
    exp_q.push_back(pack(t0 + 51, 16'd1, 16'd200, 30'h3FFFFFFF, 6'h2A));
    tick(49);
    chk("pause_busy_held", 64'(busy), 64'd1);
    pause = 1'b0;
    tick(8);
    end_check("pause", 1);

    // Full ROM, no marker, top-of-range times; entry 2 has no enables.
    for (int i = 0; i < N; i++) begin
      hit[i] = (i == N - 1) ? 16'hFFF0 : 16'(i * 16'h2000 + $urandom_range(0, 16'h1000));
      frv[i] = 30'($urandom);
      env[i] = (i == 2) ? 6'd0 : 6'($urandom_range(1, 63));
      rom[i] = ent(hit[i], frv[i], env[i]);
    end
    song = 16'hFF00;
    start_pulse(t0);
    for (int i = 0; i < N; i++)
      exp_q.push_back(pack(t0 + 4 + 4 * i, 16'(i + 1), hit[i], frv[i], env[i]));
    tick(40);
    end_check("full_rom", N);
    chk("full_rom_addr_last", 64'(rom_addr), 64'(N - 1));
    tick(5);
    chk("full_rom_addr_hold", 64'(rom_addr), 64'(N - 1));

    // Restart during EMIT of entry 3.
    clear_rom();
    for (int i = 0; i < 6; i++) begin
      hit[i] = 16'(1000 * i);
      frv[i] = 30'($urandom);
      env[i] = 6'($urandom_range(1, 63));
      rom[i] = ent(hit[i], frv[i], env[i]);
    end
    song = 16'h1000;
    start_pulse(t0);
    for (int i = 0; i < 4; i++)
      exp_q.push_back(pack(t0 + 4 + 4 * i, 16'(i + 1), hit[i], frv[i], env[i]));
    tick(15);
    start = 1'b1;
    t1 = cyc;
    for (int i = 0; i < 6; i++)
      exp_q.push_back(pack(t1 + 4 + 4 * i, 16'(i + 1), hit[i], frv[i], env[i]));
    tick(1);
    start = 1'b0;
    chk("restart_notes_cleared", 64'(notes), 64'd0);
    chk("restart_fret_en_cleared", 64'(fret_en), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    chk("restart_done", 64'(done), 64'd0);
    tick(40);
    end_check("restart", 6);

    // Random charts: some entries due at the initial song_time, the rest
    // become due when song_time jumps to the top at a known cycle.
    for (int it = 0; it < 8; it++) begin
      clear_rom();
      n  = $urandom_range(1, 6);
      tt = 16'($urandom_range(0, 3000));
      for (int i = 0; i < n; i++) begin
        hit[i] = tt;
        frv[i] = 30'($urandom);
        env[i] = 6'($urandom_range(0, 63));
        rom[i] = ent(hit[i], frv[i], env[i]);
        tt = tt + 16'($urandom_range(0, 4000));
      end
      st = 16'($urandom_range(0, 15000));
      song = st;
      start_pulse(t0);
      tr = t0 + 60;
      e  = t0;
      for (int i = 0; i < n; i++) begin
        c = e + 4;
        if (!({1'b0, hit[i]} <= {1'b0, st} + LA) && c < tr + 1) c = tr + 1;
        e = c;
        exp_q.push_back(pack(c, 16'(i + 1), hit[i], frv[i], env[i]));
      end
      tick(tr - cyc);
      song = 16'hFFFF;
      tick(e + 10 - cyc);
      end_check("random", n);
    end

    // Reset wins over a simultaneous start.
    rst = 1'b1;
    start = 1'b1;
    tick(1);
    rst = 1'b0;
    start = 1'b0;
    chk("reset_prio_busy", 64'(busy), 64'd0);
    chk("reset_prio_done", 64'(done), 64'd0);
    chk("reset_prio_notes", 64'(notes), 64'd0);
    tick(3);
    chk("reset_prio_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
